usb_tx_data_buffer: RTL and testbench
=====================================

# usb_tx_data_buffer

Transmit data FIFO that sits directly upstream of the USB TX packet path. The host/bus side writes it one byte at a time. The TX packet compiler drains it by asserting its byte-request strobe, and reads the live occupancy count to size DATA packets. The block holds up to 64 bytes (one full-speed bulk max packet), exposes the head byte show-ahead, and flags overflow/underflow misuse.

## Interface
Parameters:
- DEPTH, 64, number of byte entries; power of two.
- WIDTH, 8, bits per entry.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- n_rst  input  1  reset, synchronous, active-low; sampled on rising edge of clk.
- store_tx_data  input  1  push strobe from bus side; one byte per asserted cycle.
- tx_data  input  WIDTH  byte to push; sampled with store_tx_data.
- get_tx_packet_data  input  1  pop strobe from TX packet compiler; one byte per asserted cycle.
- clear  input  1  synchronous flush of contents and error flags.
- tx_packet_data  output  WIDTH  head-of-queue byte (show-ahead); 0 when empty.
- buffer_occupancy  output  $clog2(DEPTH)+1 (7)  bytes currently stored, 0..64.
- full  output  1  buffer_occupancy == DEPTH.
- empty  output  1  buffer_occupancy == 0.
- overflow_err  output  1  sticky; a push was rejected.
- underflow_err  output  1  sticky; a pop was rejected.

## Operation
- Storage: DEPTH x WIDTH register array. It is not reset, and contents are don't-care when not counted.
- wr_ptr and rd_ptr are $clog2(DEPTH) bits (6) and wrap naturally from 63 to 0. buffer_occupancy is a separate 7-bit register.
- Priority each cycle, highest first: reset, then clear, then push/pop evaluation.
- Reset (n_rst=0 at edge):
  - pointers = 0, occupancy = 0.
  - overflow_err = 0, underflow_err = 0.
- clear=1:
  - Same effect as reset on pointers, occupancy and error flags.
  - Any push/pop in that cycle is ignored and sets no error.
- Pop accepted when get_tx_packet_data=1 and occupancy>0:
  - rd_ptr += 1.
- Pop rejected when get_tx_packet_data=1 and occupancy==0:
  - underflow_err <= 1; rd_ptr unchanged.
- Push accepted when store_tx_data=1 and (occupancy<DEPTH or an accepted pop occurs the same cycle):
  - mem[wr_ptr] <= tx_data; wr_ptr += 1.
- Push rejected when store_tx_data=1, full, and no accepted pop:
  - overflow_err <= 1; memory and wr_ptr unchanged.
- Occupancy update: occupancy += (push accepted) - (pop accepted). Result always stays within 0..DEPTH.
- Push and pop on an empty buffer: pop rejected (underflow_err set), push accepted, occupancy becomes 1.
- Push and pop on a full buffer: both accepted, occupancy stays 64, pointers both advance.
- Error flags stay set until clear or reset; setting them does not block later operations.
- tx_packet_data = mem[rd_ptr] when occupancy>0, else 0. This is combinational from registered state.
- full and empty decode combinationally from the occupancy register.

## Timing
- Push-to-visible latency is 1 cycle. A byte pushed at edge N appears on tx_packet_data after edge N, if the buffer was empty.
- Pop takes effect at the edge. The next byte is presented after that edge, so back-to-back pops every cycle are supported.
- buffer_occupancy, full and empty update 1 cycle after the strobe edge. There is no combinational path from strobes to these outputs.
- No combinational path from store_tx_data, tx_data, get_tx_packet_data or clear to any output.
- Reset values of outputs:
  - tx_packet_data = 0, buffer_occupancy = 0, full = 0, empty = 1.
  - overflow_err = 0, underflow_err = 0.
- Reset or clear asserted mid-stream discards all content at that edge. The consumer sees empty=1 the next cycle.

## Test plan
- Reset, then push 0xA5 -> next cycle tx_packet_data=0xA5, occupancy=1, empty=0. Pop -> occupancy=0, tx_packet_data=0, empty=1.
- Push bytes 0x00..0x3F (64 cycles) -> occupancy=64, full=1. 65th push of 0xFF -> overflow_err=1, occupancy=64. Then 64 pops return 0x00..0x3F in order.
- Pointer wrap: push 40, pop 40, push 40, pop 40 -> data order preserved across wrap, occupancy ends 0, no error flags.
- Simultaneous push+pop: on full (value 0x77 pushed) -> occupancy stays 64, no overflow, 0x77 emerges last. On empty -> underflow_err=1, occupancy=1, head=pushed byte.
- Pop on empty -> underflow_err=1, occupancy stays 0. Then clear -> both flags 0.
- Push 10 bytes, then assert clear together with push and pop -> next cycle occupancy=0, empty=1, flags 0. Repeat the scenario with n_rst=0 in place of clear -> same result.

Source files
------------

// File: rtl/usb_tx_data_buffer_if.sv
// Byte-stream interface between the bus-side writer, the TX packet compiler
// and the transmit data buffer. The master is the pair of clients; the slave
// is the buffer itself.
interface usb_tx_data_buffer_if #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 8
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             store_tx_data;
  logic [WIDTH-1:0] tx_data;
  logic             get_tx_packet_data;
  logic             clear;
  logic [WIDTH-1:0] tx_packet_data;
  logic [CNT_W-1:0] buffer_occupancy;
  logic             full;
  logic             empty;
  logic             overflow_err;
  logic             underflow_err;

  modport master (
    output store_tx_data, tx_data, get_tx_packet_data, clear,
    input  tx_packet_data, buffer_occupancy, full, empty,
           overflow_err, underflow_err
  );

  modport slave (
    input  store_tx_data, tx_data, get_tx_packet_data, clear,
    output tx_packet_data, buffer_occupancy, full, empty,
           overflow_err, underflow_err
  );
endinterface

// File: rtl/usb_tx_data_buffer.sv
// Transmit data FIFO feeding the USB TX packet path. Byte-wide pushes from
// the bus side, byte-wide pops from the packet compiler, show-ahead head
// byte, live occupancy count and sticky overflow/underflow flags.
module usb_tx_data_buffer #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 8
) (
  input logic                clk,
  input logic                n_rst,
  usb_tx_data_buffer_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] occupancy;
  logic             overflow_err;
  logic             underflow_err;

  logic is_empty;
  logic is_full;
  logic pop_ok;
  logic push_ok;
  logic pop_bad;
  logic push_bad;

  // Accept/reject decode; clear suppresses every operation and error in its cycle.
  always_comb begin
    is_empty = (occupancy == '0);
    is_full  = (occupancy == FULL_CNT);
    pop_ok   = bus.get_tx_packet_data && !is_empty && !bus.clear;
    pop_bad  = bus.get_tx_packet_data && is_empty && !bus.clear;
    push_ok  = bus.store_tx_data && (!is_full || pop_ok) && !bus.clear;
    push_bad = bus.store_tx_data && is_full && !pop_ok && !bus.clear;
  end

  // Pointer, occupancy and sticky error state with reset/clear priority.
  always_ff @(posedge clk) begin
    if (!n_rst || bus.clear) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      occupancy     <= '0;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   occupancy <= occupancy + CNT_W'(1);
        2'b01:   occupancy <= occupancy - CNT_W'(1);
        default: occupancy <= occupancy;
      endcase
      if (push_bad) overflow_err  <= 1'b1;
      if (pop_bad)  underflow_err <= 1'b1;
    end
  end

  // Byte storage; never reset, only slots counted by occupancy are meaningful.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= bus.tx_data;
  end

  // Show-ahead head byte and status decode, all from registered state.
  always_comb begin
    bus.tx_packet_data   = is_empty ? '0 : mem[rd_ptr];
    bus.buffer_occupancy = occupancy;
    bus.full             = is_full;
    bus.empty            = is_empty;
    bus.overflow_err     = overflow_err;
    bus.underflow_err    = underflow_err;
  end
endmodule

// File: tb/tb_usb_tx_data_buffer.sv
// Bench for usb_tx_data_buffer: directed scenarios with literal expectations
// followed by randomized traffic, all compared against a queue-based model.
module tb_usb_tx_data_buffer;
  localparam int DEPTH = 64;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  bit   cmp_en = 1'b0;

  usb_tx_data_buffer_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

  usb_tx_data_buffer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: a byte queue plus two sticky flags.
  logic [7:0] q[$];
  bit         m_of = 1'b0;
  bit         m_uf = 1'b0;

  always @(posedge clk) begin
    bit pop, push;
    if (!n_rst || bus.clear) begin
      q.delete();
      m_of = 1'b0;
      m_uf = 1'b0;
    end else begin
      pop  = bus.get_tx_packet_data && (q.size() > 0);
      push = bus.store_tx_data && ((q.size() < DEPTH) || pop);
      if (bus.get_tx_packet_data && q.size() == 0) m_uf = 1'b1;
      if (bus.store_tx_data && !push) m_of = 1'b1;
      if (pop) void'(q.pop_front());
      if (push) q.push_back(bus.tx_data);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_occ", 32'(bus.buffer_occupancy), 32'(q.size()));
      chk("m_head", 32'(bus.tx_packet_data), (q.size() > 0) ? 32'(q[0]) : 32'd0);
      chk("m_full", 32'(bus.full), 32'(q.size() == DEPTH));
      chk("m_empty", 32'(bus.empty), 32'(q.size() == 0));
      chk("m_of", 32'(bus.overflow_err), 32'(m_of));
      chk("m_uf", 32'(bus.underflow_err), 32'(m_uf));
    end
  end

  // Apply one cycle of inputs; returns just after the edge that consumed them.
  task automatic cyc(input bit s, input logic [7:0] d, input bit g, input bit c);
    bus.store_tx_data      = s;
    bus.tx_data            = d;
    bus.get_tx_packet_data = g;
    bus.clear              = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.store_tx_data      = 1'b0;
    bus.tx_data            = '0;
    bus.get_tx_packet_data = 1'b0;
    bus.clear              = 1'b0;
    @(posedge clk);
    #1;
    cmp_en = 1'b1;
    cyc(0, 0, 0, 0);
    n_rst = 1'b1;
    chk("rst_head", 32'(bus.tx_packet_data), 0);
    chk("rst_occ", 32'(bus.buffer_occupancy), 0);
    chk("rst_full", 32'(bus.full), 0);
    chk("rst_empty", 32'(bus.empty), 1);
    chk("rst_of", 32'(bus.overflow_err), 0);
    chk("rst_uf", 32'(bus.underflow_err), 0);

    // Single byte round trip
    cyc(1, 8'hA5, 0, 0);
    chk("one_head", 32'(bus.tx_packet_data), 32'hA5);
    chk("one_occ", 32'(bus.buffer_occupancy), 1);
    chk("one_empty", 32'(bus.empty), 0);
    cyc(0, 0, 1, 0);
    chk("one_pop_occ", 32'(bus.buffer_occupancy), 0);
    chk("one_pop_head", 32'(bus.tx_packet_data), 0);
    chk("one_pop_empty", 32'(bus.empty), 1);

    // Fill, overflow, drain in order
    for (int i = 0; i < 64; i++) cyc(1, 8'(i), 0, 0);
    chk("fill_occ", 32'(bus.buffer_occupancy), 64);
    chk("fill_full", 32'(bus.full), 1);
    cyc(1, 8'hFF, 0, 0);
    chk("ovf_flag", 32'(bus.overflow_err), 1);
    chk("ovf_occ", 32'(bus.buffer_occupancy), 64);
    for (int i = 0; i < 64; i++) begin
      chk("drain_head", 32'(bus.tx_packet_data), 32'(i));
      cyc(0, 0, 1, 0);
    end
    chk("drain_empty", 32'(bus.empty), 1);
    cyc(0, 0, 0, 1);
    chk("clr_of", 32'(bus.overflow_err), 0);

    // Pointer wrap: two rounds of 40
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 40; i++) cyc(1, 8'(i * 3 + r), 0, 0);
      for (int i = 0; i < 40; i++) begin
        chk("wrap_head", 32'(bus.tx_packet_data), 32'(8'(i * 3 + r)));
        cyc(0, 0, 1, 0);
      end
    end
    chk("wrap_occ", 32'(bus.buffer_occupancy), 0);
    chk("wrap_of", 32'(bus.overflow_err), 0);
    chk("wrap_uf", 32'(bus.underflow_err), 0);

    // Simultaneous push+pop on full and on empty
    for (int i = 0; i < 64; i++) cyc(1, 8'(i + 8'h80), 0, 0);
    cyc(1, 8'h77, 1, 0);
    chk("fpp_occ", 32'(bus.buffer_occupancy), 64);
    chk("fpp_of", 32'(bus.overflow_err), 0);
    chk("fpp_head", 32'(bus.tx_packet_data), 32'h81);
    for (int i = 0; i < 63; i++) cyc(0, 0, 1, 0);
    chk("fpp_last", 32'(bus.tx_packet_data), 32'h77);
    cyc(0, 0, 1, 0);
    cyc(1, 8'h5A, 1, 0);
    chk("epp_uf", 32'(bus.underflow_err), 1);
    chk("epp_occ", 32'(bus.buffer_occupancy), 1);
    chk("epp_head", 32'(bus.tx_packet_data), 32'h5A);
    cyc(0, 0, 0, 1);

    // Underflow then clear
    cyc(0, 0, 1, 0);
    chk("uf_flag", 32'(bus.underflow_err), 1);
    chk("uf_occ", 32'(bus.buffer_occupancy), 0);
    cyc(0, 0, 0, 1);
    chk("uf_clr_uf", 32'(bus.underflow_err), 0);
    chk("uf_clr_of", 32'(bus.overflow_err), 0);

    // Clear, then reset, mid-stream with push and pop active
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 10; i++) cyc(1, 8'(i + 1), 0, 0);
      if (k == 1) n_rst = 1'b0;
      cyc(1, 8'h11, 1, (k == 0));
      n_rst = 1'b1;
      chk("flush_occ", 32'(bus.buffer_occupancy), 0);
      chk("flush_empty", 32'(bus.empty), 1);
      chk("flush_of", 32'(bus.overflow_err), 0);
      chk("flush_uf", 32'(bus.underflow_err), 0);
    end

    // Randomized traffic with shifting push/pop bias
    for (int i = 0; i < 4000; i++) begin
      int ps, pp;
      ps = ((i / 500) % 2 == 0) ? 70 : 35;
      pp = ((i / 500) % 2 == 0) ? 35 : 70;
      n_rst = ($urandom_range(0, 499) != 0);
      cyc(($urandom_range(0, 99) < ps), 8'($urandom), ($urandom_range(0, 99) < pp),
          ($urandom_range(0, 199) == 0));
    end
    n_rst = 1'b1;
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    @(negedge clk);
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
